// File: rtl/ro_uart_sequencer_if.sv
// Handshake bundle between the RO sequencer and the UART cores, sum datapath and TX byte mux.
// The master modport is the sequencer side; the slave modport is the surrounding datapath.
interface ro_uart_sequencer_if #(
  parameter int unsigned SEL_W = 2,
  parameter int unsigned CH_W  = 2
);
  logic             sum_ready;
  logic             tx_busy;
  logic             rx_ready;
  logic [7:0]       rx_data;
  logic             sum_en;
  logic             tx_send;
  logic [SEL_W-1:0] send_sel;
  logic [CH_W-1:0]  ch_sel;
  logic             running;

  modport master (
    input  sum_ready, tx_busy, rx_ready, rx_data,
    output sum_en, tx_send, send_sel, ch_sel, running
  );

  modport slave (
    output sum_ready, tx_busy, rx_ready, rx_data,
    input  sum_en, tx_send, send_sel, ch_sel, running
  );
endinterface

// File: rtl/ro_uart_sequencer.sv
// Command/response sequencer for the ring-oscillator temperature sensor.
// Decodes UART command bytes, gates the sum datapath and streams each result as a byte frame.
// Optional feature macro: SEQ_HEADER_EN prepends a header byte (send_sel == NBYTES) to
// every frame.
module ro_uart_sequencer #(
  parameter int unsigned NBYTES     = 3,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned NCH        = 4,
  parameter int unsigned CH_W       = 2,
  parameter int unsigned GAP_CYCLES = 100
) (
  input logic                clk,
  input logic                reset_n,
  ro_uart_sequencer_if.master bus
);

  localparam logic [SEL_W-1:0] LastIdx = SEL_W'(NBYTES - 1);
`ifdef SEQ_HEADER_EN
  localparam logic [SEL_W-1:0] HdrIdx   = SEL_W'(NBYTES);
  localparam logic [SEL_W-1:0] FirstIdx = HdrIdx;
`else
  localparam logic [SEL_W-1:0] FirstIdx = '0;
`endif
  localparam logic [15:0] Gap = 16'(GAP_CYCLES);

  typedef enum logic [2:0] {StIdle, StDecode, StWaitSum, StSend, StWaitTx} state_e;

  state_e           state_q, state_d;
  logic [7:0]       cmd_q, cmd_d;
  logic             pending_q, pending_d;
  logic             running_q, running_d;
  logic [CH_W-1:0]  ch_sel_q, ch_sel_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [15:0]      timer_q, timer_d;

  logic             sum_en, tx_send;
  logic [SEL_W-1:0] send_sel;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      pending_q <= 1'b0;
      running_q <= 1'b0;
      ch_sel_q  <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      pending_q <= pending_d;
      running_q <= running_d;
      ch_sel_q  <= ch_sel_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
    end
  end

  // Next-state logic: command decode, frame sequencing and byte index.
  always_comb begin
    state_d   = state_q;
    running_d = running_q;
    ch_sel_d  = ch_sel_q;
    idx_d     = idx_q;
    case (state_q)
      StIdle: begin
        if (pending_q) state_d = StDecode;
      end
      StDecode: begin
        if (cmd_q == 8'h00) begin
          running_d = 1'b1;
          state_d   = StWaitSum;
        end else if (cmd_q == 8'h01) begin
          running_d = 1'b0;
          state_d   = StWaitSum;
        end else if (cmd_q == 8'h02) begin
          running_d = 1'b0;
          state_d   = StIdle;
        end else begin
          if (cmd_q[7:4] == 4'h1 && 32'(cmd_q[3:0]) < NCH) ch_sel_d = cmd_q[CH_W-1:0];
          state_d = running_q ? StWaitSum : StIdle;
        end
      end
      StWaitSum: begin
        // A pending command beats a finished result.
        if (pending_q) begin
          state_d = StDecode;
        end else if (bus.sum_ready) begin
          idx_d   = FirstIdx;
          state_d = StSend;
        end
      end
      StSend: begin
        if (!bus.tx_busy) state_d = StWaitTx;
      end
      StWaitTx: begin
        if (timer_q >= Gap && !bus.tx_busy) begin
          if (idx_q == LastIdx) begin
            state_d = running_q ? StWaitSum : StIdle;
          end else begin
`ifdef SEQ_HEADER_EN
            idx_d = (idx_q == HdrIdx) ? '0 : idx_q + SEL_W'(1);
`else
            idx_d = idx_q + SEL_W'(1);
`endif
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Command capture and state timer; a new byte wins over the clear on DECODE entry.
  always_comb begin
    cmd_d     = cmd_q;
    pending_d = pending_q;
    if (state_d == StDecode) pending_d = 1'b0;
    if (bus.rx_ready) begin
      pending_d = 1'b1;
      cmd_d     = bus.rx_data;
    end
    if (state_d != state_q) timer_d = '0;
    else if (timer_q == 16'hFFFF) timer_d = timer_q;
    else timer_d = timer_q + 16'd1;
  end

  // Outputs decoded from the registered state.
  always_comb begin
    sum_en   = (state_q == StWaitSum);
    tx_send  = (state_q == StSend) && !bus.tx_busy;
    send_sel = (state_q == StSend || state_q == StWaitTx) ? idx_q : '0;
  end

  assign bus.sum_en   = sum_en;
  assign bus.tx_send  = tx_send;
  assign bus.send_sel = send_sel;
  assign bus.ch_sel   = ch_sel_q;
  assign bus.running  = running_q;

endmodule

// File: tb/tb_ro_uart_sequencer.sv
// Self-checking bench for ro_uart_sequencer: directed corner cases plus randomized commands
// checked against a transaction-level model (mode, channel, expected frame byte order).
module tb_ro_uart_sequencer;
  localparam int unsigned NB  = 3;
  localparam int unsigned SW  = 2;
  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 2;
  localparam int unsigned GAP = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  ro_uart_sequencer_if #(.SEL_W(SW), .CH_W(CW)) bus ();

  ro_uart_sequencer #(
    .NBYTES(NB), .SEL_W(SW), .NCH(NCH), .CH_W(CW), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model state.
  int exp_frame[$];
  bit m_running = 0;
  bit m_active = 0;
  int m_ch = 0;

  function automatic void model_cmd(input logic [7:0] c);
    if (c == 8'h00) begin
      m_running = 1; m_active = 1;
    end else if (c == 8'h01) begin
      m_running = 0; m_active = 1;
    end else if (c == 8'h02) begin
      m_running = 0; m_active = 0;
    end else begin
      if (c[7:4] == 4'h1 && int'(c[3:0]) < NCH) m_ch = int'(c[3:0]);
      m_active = m_running;
    end
  endfunction

  // Pulse monitor: records send_sel per tx_send and checks spacing and busy.
  int cyc = 0;
  int last_pulse = -1;
  int sel_q[$];
  int pulse_cyc[$];
  int busy_len = 0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n && bus.tx_send) begin
        check("send_while_busy", bus.tx_busy, 0);
        if (last_pulse >= 0) check("pulse_gap", (cyc - last_pulse) >= int'(GAP + 1), 1);
        last_pulse = cyc;
        sel_q.push_back(int'(bus.send_sel));
        pulse_cyc.push_back(cyc);
      end
    end
  end

  // UART TX emulation: busy rises the cycle after a send and lasts busy_len cycles.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.tx_send && busy_len > 0) begin
        @(posedge clk);
        #1 bus.tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 bus.tx_busy = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(posedge clk);
    #1 bus.rx_data = b;
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1 bus.rx_ready = 1'b0;
  endtask

  task automatic pulse_sum_ready();
    @(posedge clk);
    #1 bus.sum_ready = 1'b1;
    @(posedge clk);
    #1 bus.sum_ready = 1'b0;
  endtask

  task automatic wait_pulses(input int n, input int budget);
    int k = 0;
    while (sel_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("pulse_arrival", sel_q.size() >= n, 1);
  endtask

  task automatic check_frame();
    check("frame_len", sel_q.size(), exp_frame.size());
    for (int i = 0; i < exp_frame.size(); i++) begin
      if (i < sel_q.size()) check("frame_sel", sel_q[i], exp_frame[i]);
    end
    sel_q.delete();
    pulse_cyc.delete();
  endtask

  function automatic int frame_budget(input int busy);
    return exp_frame.size() * (GAP + 4 + busy) + 50;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    logic [7:0] c;
`ifdef SEQ_HEADER_EN
    exp_frame.push_back(NB);
`endif
    for (int i = 0; i < NB; i++) exp_frame.push_back(i);

    bus.rx_ready = 1'b0;
    bus.rx_data = 8'h00;
    bus.sum_ready = 1'b0;
    reset_n = 1'b0;
    tick(3);
    @(negedge clk);
    check("rst_sum_en", bus.sum_en, 0);
    check("rst_tx_send", bus.tx_send, 0);
    check("rst_send_sel", bus.send_sel, 0);
    check("rst_ch_sel", bus.ch_sel, 0);
    check("rst_running", bus.running, 0);
    reset_n = 1'b1;
    tick(2);

    // START: DECODE at cycle 2, sum_en at cycle 3.
    @(posedge clk);
    #1 bus.rx_data = 8'h00;
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1 bus.rx_ready = 1'b0;
    @(negedge clk);
    check("start_lat_c1", bus.sum_en, 0);
    @(negedge clk);
    check("start_lat_c2", bus.sum_en, 0);
    @(negedge clk);
    check("start_lat_c3", bus.sum_en, 1);
    check("start_running", bus.running, 1);
    model_cmd(8'h00);

    // Result to first tx_send in one cycle.
    pulse_sum_ready();
    @(negedge clk);
    check("send_latency", bus.tx_send, 1);
    wait_pulses(exp_frame.size(), frame_budget(0));
    check_frame();
    tick(GAP + 10);
    check("cont_sum_en", bus.sum_en, 1);

    // SINGLE: one frame then idle.
    send_cmd(8'h01);
    model_cmd(8'h01);
    tick(5);
    check("single_running", bus.running, 0);
    check("single_sum_en", bus.sum_en, 1);
    pulse_sum_ready();
    wait_pulses(exp_frame.size(), frame_budget(0));
    check_frame();
    tick(GAP + 10);
    check("single_idle_sum_en", bus.sum_en, 0);
    check("single_idle_run", bus.running, 0);

    // Channel select while idle, out-of-range channel ignored.
    send_cmd(8'h12);
    tick(5);
    check("ch_sel_2", bus.ch_sel, 2);
    check("ch_idle_sum_en", bus.sum_en, 0);
    send_cmd(8'h17);
    tick(5);
    check("ch_sel_keep", bus.ch_sel, 2);
    model_cmd(8'h12);
    model_cmd(8'h17);

    // Long TX busy after the first byte.
    send_cmd(8'h00);
    model_cmd(8'h00);
    tick(5);
    busy_len = 500;
    pulse_sum_ready();
    t0 = 0;
    while (!bus.tx_busy && t0 < 20) begin
      @(negedge clk);
      t0++;
    end
    check("busy_raised", bus.tx_busy, 1);
    busy_len = 0;
    wait_pulses(2, 700);
    if (pulse_cyc.size() >= 2) check("busy_hold_gap", (pulse_cyc[1] - pulse_cyc[0]) >= 501, 1);
    wait_pulses(exp_frame.size(), frame_budget(0));
    check_frame();
    tick(GAP + 10);

    // Pending command and sum_ready together in WAIT_SUM: decode wins, no frame.
    @(posedge clk);
    #1 bus.rx_data = 8'h13;
    bus.rx_ready = 1'b1;
    @(posedge clk);
    #1 bus.rx_ready = 1'b0;
    bus.sum_ready = 1'b1;
    @(posedge clk);
    #1 bus.sum_ready = 1'b0;
    model_cmd(8'h13);
    tick(3 * GAP);
    check("pend_no_frame", sel_q.size(), 0);
    check("pend_ch_sel", bus.ch_sel, 3);
    check("pend_sum_en", bus.sum_en, 1);

    // STOP mid-frame: frame completes, then idle.
    pulse_sum_ready();
    wait_pulses(1, 20);
    send_cmd(8'h02);
    model_cmd(8'h02);
    wait_pulses(exp_frame.size(), frame_budget(0));
    check_frame();
    tick(GAP + 10);
    check("stop_sum_en", bus.sum_en, 0);
    check("stop_running", bus.running, 0);
    tick(GAP);
    check("stop_no_more", sel_q.size(), 0);

    // Randomized commands against the model.
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 5))
        0: c = 8'h00;
        1: c = 8'h01;
        2: c = 8'h02;
        3: c = 8'h10 + 8'($urandom_range(0, NCH - 1));
        4: c = 8'h10 + 8'($urandom_range(NCH, 15));
        default: c = 8'($urandom_range(0, 255));
      endcase
      busy_len = $urandom_range(0, 150);
      send_cmd(c);
      model_cmd(c);
      tick(6);
      check("rnd_sum_en", bus.sum_en, m_active);
      check("rnd_running", bus.running, m_running);
      check("rnd_ch_sel", bus.ch_sel, m_ch);
      pulse_sum_ready();
      if (m_active) begin
        wait_pulses(exp_frame.size(), frame_budget(busy_len));
        check_frame();
        tick(GAP + busy_len + 20);
        m_active = m_running;
      end else begin
        tick(20);
        check("rnd_idle_no_frame", sel_q.size(), 0);
      end
      check("rnd_post_sum_en", bus.sum_en, m_active);
    end
    busy_len = 0;
    tick(200);

    // Reset mid-frame: outputs clear asynchronously, no further pulses.
    send_cmd(8'h11);
    send_cmd(8'h00);
    tick(5);
    sel_q.delete();
    pulse_sum_ready();
    wait_pulses(2, frame_budget(0));
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_sum_en", bus.sum_en, 0);
    check("arst_tx_send", bus.tx_send, 0);
    check("arst_send_sel", bus.send_sel, 0);
    check("arst_ch_sel", bus.ch_sel, 0);
    check("arst_running", bus.running, 0);
    last_pulse = -1;
    sel_q.delete();
    pulse_cyc.delete();
    tick(5);
    reset_n = 1'b1;
    tick(400);
    check("arst_no_pulse", sel_q.size(), 0);
    check("arst_idle", bus.sum_en, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
